spike_generator_scheduler: RTL and testbench

- Time-multiplexed controller for the FPGA spike generators: holds per-generator programming {period, ticks, tag} in a single state memory and sweeps the used generators once per FPGA time unit.
- Each expiring generator emits one tag/count word upstream.
- Sits between the PC-side SpikeGeneratorProgChannel decoder and the tag merge toward BD.
- Takes gens_used/gens_en from the SpikeGeneratorConf register bundle and the time-unit pulse from the time manager.

---
 rtl/spike_generator_scheduler_pkg.sv | 34 +++
 rtl/spike_generator_scheduler_gen_state_ram.sv | 27 ++
 rtl/spike_generator_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_spike_generator_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_generator_scheduler_pkg.sv
// Shared widths, FSM state encoding and generator entry layout for the
// time-multiplexed spike generator scheduler.
package spike_generator_scheduler_pkg;

  localparam int NGENS    = 8;
  localparam int NPERIOD  = 16;
  localparam int NTAG     = 11;
  localparam int NCT      = 9;
  localparam int NENTRIES = 1 << NGENS;
  localparam int ENTRY_W  = 2 * NPERIOD + NTAG;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [NPERIOD-1:0] period;
    logic [NPERIOD-1:0] ticks;
    logic [NTAG-1:0]    tag;
  } entry_t;

  // Countdown after one time unit: expired entries reload to period-1.
  function automatic logic [NPERIOD-1:0] next_ticks(input entry_t e);
    if (e.ticks == {NPERIOD{1'b0}}) begin
      return e.period - NPERIOD'(1);
    end else begin
      return e.ticks - NPERIOD'(1);
    end
  endfunction

endpackage

// File: rtl/spike_generator_scheduler_gen_state_ram.sv
// Simple dual-port state memory holding one packed entry per generator,
// with a registered (1-cycle) read port.
module spike_generator_scheduler_gen_state_ram
  import spike_generator_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [NGENS-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [NGENS-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_r [NENTRIES];

  // Write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/spike_generator_scheduler.sv
// Sweeps generators 0..gens_used once per time unit, decrementing each
// countdown and emitting one tag word for every expiring generator.
module spike_generator_scheduler
  import spike_generator_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NGENS-1:0]    gens_used,
  input  logic [NENTRIES-1:0] gens_en,
  input  logic                time_unit_pulse,
  input  logic [NGENS-1:0]    prog_gen_idx,
  input  logic [NPERIOD-1:0]  prog_period,
  input  logic [NPERIOD-1:0]  prog_ticks,
  input  logic [NTAG-1:0]     prog_tag,
  input  logic                prog_v,
  output logic                prog_a,
  output logic [NTAG-1:0]     out_tag,
  output logic [NCT-1:0]      out_ct,
  output logic                out_v,
  input  logic                out_a,
  output logic                overrun
);

  state_e              state_r, state_s;
  logic [NGENS-1:0]    idx_r, idx_s;
  logic [NGENS-1:0]    used_r, used_s;
  logic                pending_r, pending_s;
  logic                overrun_r, overrun_s;
  logic [NENTRIES-1:0] valid_r;
  logic                prog_a_r, accept_s;
  logic                out_v_r;
  logic [NTAG-1:0]     out_tag_r;
  logic [NCT-1:0]      out_ct_r;

  logic                prog_write_s;
  logic                upd_we_s;
  logic                emit_s;
  logic                skip_s;
  logic                last_s;
  entry_t              rd_entry_s;
  entry_t              upd_entry_s;
  entry_t              prog_entry_s;
  logic [ENTRY_W-1:0]  rdata_s;
  logic                ram_we_s;
  logic [NGENS-1:0]    ram_waddr_s;
  logic [ENTRY_W-1:0]  ram_wdata_s;

  assign rd_entry_s   = entry_t'(rdata_s);
  assign prog_entry_s = '{period: prog_period, ticks: prog_ticks, tag: prog_tag};
  assign prog_write_s = prog_a_r && prog_v;
  assign last_s       = (idx_r == used_r);
  assign skip_s       = !valid_r[idx_r] || !gens_en[idx_r] ||
                        (rd_entry_s.period == {NPERIOD{1'b0}});

  // Prog writes only happen in IDLE and write-backs only in UPDATE, so one port suffices.
  assign ram_we_s    = prog_write_s || upd_we_s;
  assign ram_waddr_s = upd_we_s ? idx_r : prog_gen_idx;
  assign ram_wdata_s = upd_we_s ? upd_entry_s : prog_entry_s;

  spike_generator_scheduler_gen_state_ram u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (state_r == ST_READ),
    .raddr (idx_r),
    .rdata (rdata_s)
  );

  // Next-state, sweep bookkeeping, write-back and time-unit overrun tracking.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    used_s      = used_r;
    pending_s   = pending_r;
    overrun_s   = overrun_r;
    accept_s    = 1'b0;
    upd_we_s    = 1'b0;
    emit_s      = 1'b0;
    upd_entry_s = rd_entry_s;

    if (time_unit_pulse && (state_r != ST_IDLE)) begin
      if (pending_r) begin
        overrun_s = 1'b1;
      end else begin
        pending_s = 1'b1;
      end
    end else begin
      overrun_s = overrun_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (pending_r || time_unit_pulse) begin
          state_s   = ST_READ;
          idx_s     = {NGENS{1'b0}};
          used_s    = gens_used;
          // A fresh pulse landing while a pending sweep launches is kept, not lost.
          pending_s = pending_r && time_unit_pulse;
        end else if (prog_v && !prog_a_r) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_READ: begin
        state_s = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (!skip_s) begin
          upd_we_s          = 1'b1;
          upd_entry_s.ticks = next_ticks(rd_entry_s);
          emit_s            = (rd_entry_s.ticks == {NPERIOD{1'b0}});
        end else begin
          upd_we_s = 1'b0;
        end
        if (emit_s) begin
          state_s = ST_EMIT;
        end else if (last_s) begin
          state_s = ST_IDLE;
        end else begin
          idx_s   = idx_r + NGENS'(1);
          state_s = ST_READ;
        end
      end
      ST_EMIT: begin
        if (!out_a) begin
          state_s = ST_EMIT;
        end else if (last_s) begin
          state_s = ST_IDLE;
        end else begin
          idx_s   = idx_r + NGENS'(1);
          state_s = ST_READ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, valid bits and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= {NGENS{1'b0}};
      used_r    <= {NGENS{1'b0}};
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
      valid_r   <= {NENTRIES{1'b0}};
      prog_a_r  <= 1'b0;
      out_v_r   <= 1'b0;
      out_tag_r <= {NTAG{1'b0}};
      out_ct_r  <= {NCT{1'b0}};
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      used_r    <= used_s;
      pending_r <= pending_s;
      overrun_r <= overrun_s;
      prog_a_r  <= accept_s;
      if (prog_write_s) begin
        valid_r[prog_gen_idx] <= 1'b1;
      end
      if (emit_s) begin
        out_v_r   <= 1'b1;
        out_tag_r <= rd_entry_s.tag;
        out_ct_r  <= NCT'(1);
      end else if ((state_r == ST_EMIT) && out_a) begin
        out_v_r <= 1'b0;
      end
    end
  end

  assign prog_a  = prog_a_r;
  assign out_v   = out_v_r;
  assign out_tag = out_tag_r;
  assign out_ct  = out_ct_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_spike_generator_scheduler.sv
// Self-checking bench: directed scenarios plus randomized programming, with an
// abstract per-generator countdown model producing the expected tag stream.
module tb_spike_generator_scheduler;
  import spike_generator_scheduler_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NGENS-1:0]    gens_used;
  logic [NENTRIES-1:0] gens_en;
  logic                time_unit_pulse;
  logic [NGENS-1:0]    prog_gen_idx;
  logic [NPERIOD-1:0]  prog_period;
  logic [NPERIOD-1:0]  prog_ticks;
  logic [NTAG-1:0]     prog_tag;
  logic                prog_v;
  logic                prog_a;
  logic [NTAG-1:0]     out_tag;
  logic [NCT-1:0]      out_ct;
  logic                out_v;
  logic                out_a;
  logic                overrun;

  always #5 clk = ~clk;

  spike_generator_scheduler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .gens_used       (gens_used),
    .gens_en         (gens_en),
    .time_unit_pulse (time_unit_pulse),
    .prog_gen_idx    (prog_gen_idx),
    .prog_period     (prog_period),
    .prog_ticks      (prog_ticks),
    .prog_tag        (prog_tag),
    .prog_v          (prog_v),
    .prog_a          (prog_a),
    .out_tag         (out_tag),
    .out_ct          (out_ct),
    .out_v           (out_v),
    .out_a           (out_a),
    .overrun         (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_words  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each generator is a countdown of remaining time units.
  int unsigned     m_period [NENTRIES];
  int unsigned     m_cnt    [NENTRIES];
  logic [NTAG-1:0] m_tag    [NENTRIES];
  bit              m_valid  [NENTRIES];
  logic [NTAG-1:0] exp_q[$];

  task automatic model_sweep();
    for (int g = 0; g <= int'(gens_used); g++) begin
      if (m_valid[g] && gens_en[g] && (m_period[g] != 0)) begin
        if (m_cnt[g] == 0) begin
          exp_q.push_back(m_tag[g]);
          m_cnt[g] = m_period[g] - 1;
        end else begin
          m_cnt[g] = m_cnt[g] - 1;
        end
      end
    end
  endtask

  task automatic model_prog(input int g, input int p, input int t, input int tag);
    m_period[g] = p;
    m_cnt[g]    = t;
    m_tag[g]    = NTAG'(tag);
    m_valid[g]  = 1'b1;
  endtask

  // Output side: ack policy, stability while stalled, scoreboard compare.
  int              ack_mode  = 0;
  int              stall_cnt = 0;
  bit              prev_stall = 1'b0;
  logic [NTAG-1:0] held_tag;

  always @(negedge clk) begin
    logic a;
    if (!reset_n) begin
      out_a      = 1'b0;
      stall_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_out_v", out_v, 1);
        check_eq("stall_out_tag", out_tag, held_tag);
      end
      case (ack_mode)
        0:       a = 1'b1;
        1:       a = 1'($urandom_range(0, 1));
        2:       a = 1'b0;
        3:       a = (stall_cnt >= 10);
        default: a = 1'b1;
      endcase
      if (out_v && a) stall_cnt = 0;
      else if (out_v) stall_cnt++;
      out_a = a;
      if (out_v && a) begin
        n_words++;
        if (exp_q.size() == 0) begin
          check_eq("extra_word", out_tag, 32'hFFFF_FFFF);
        end else begin
          check_eq("word_tag", out_tag, exp_q.pop_front());
        end
        check_eq("word_ct", out_ct, 1);
      end
      prev_stall = out_v && !a;
      held_tag   = out_tag;
    end
  end

  task automatic program_gen(input int g, input int p, input int t, input int tag);
    bit got = 1'b0;
    @(negedge clk);
    prog_gen_idx = NGENS'(g);
    prog_period  = NPERIOD'(p);
    prog_ticks   = NPERIOD'(t);
    prog_tag     = NTAG'(tag);
    prog_v       = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (prog_a) got = 1'b1;
    end
    check_eq("prog_accept", got, 1);
    @(negedge clk);
    prog_v = 1'b0;
    if (got) model_prog(g, p, t, tag);
  endtask

  task automatic time_unit(input int gap, input bit do_model);
    @(negedge clk);
    time_unit_pulse = 1'b1;
    if (do_model) model_sweep();
    @(negedge clk);
    time_unit_pulse = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int base;
    int cyc;
    bit seen;
    reset_n         = 1'b0;
    gens_used       = '0;
    gens_en         = '0;
    time_unit_pulse = 1'b0;
    prog_gen_idx    = '0;
    prog_period     = '0;
    prog_ticks      = '0;
    prog_tag        = '0;
    prog_v          = 1'b0;
    for (int g = 0; g < NENTRIES; g++) m_valid[g] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_v", out_v, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_out_ct", out_ct, 0);
    check_eq("rst_prog_a", prog_a, 0);
    check_eq("rst_overrun", overrun, 0);
    reset_n = 1'b1;

    // Period 3 from ticks 0: spikes on pulses 1, 4 and 7 only.
    gens_en[0] = 1'b1;
    program_gen(0, 3, 0, 'h05);
    base = n_words;
    for (int i = 0; i < 7; i++) begin
      time_unit(20, 1'b1);
      check_eq("t1_drain", exp_q.size(), 0);
    end
    check_eq("t1_word_total", n_words - base, 3);

    // Three period-1 generators, each word stalled 10 cycles.
    gens_used = NGENS'(2);
    gens_en[2:0] = 3'b111;
    program_gen(0, 1, 0, 'h10);
    program_gen(1, 1, 0, 'h11);
    program_gen(2, 1, 0, 'h12);
    ack_mode = 3;
    base = n_words;
    for (int i = 0; i < 3; i++) begin
      time_unit(100, 1'b1);
      check_eq("t2_drain", exp_q.size(), 0);
    end
    check_eq("t2_word_total", n_words - base, 9);
    ack_mode = 0;

    // Programming collides with a pulse: the sweep goes first on old data.
    @(negedge clk);
    prog_gen_idx    = NGENS'(1);
    prog_period     = NPERIOD'(1);
    prog_ticks      = NPERIOD'(0);
    prog_tag        = NTAG'('h21);
    prog_v          = 1'b1;
    time_unit_pulse = 1'b1;
    model_sweep();
    @(negedge clk);
    time_unit_pulse = 1'b0;
    check_eq("t3_no_prog_a_in_sweep", prog_a, 0);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (prog_a) seen = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    check_eq("t3_prog_accepted", seen, 1);
    check_eq("t3_prog_after_sweep", (cyc >= 6), 1);
    @(negedge clk);
    prog_v = 1'b0;
    if (seen) model_prog(1, 1, 0, 'h21);
    repeat (30) @(negedge clk);
    check_eq("t3_drain", exp_q.size(), 0);
    time_unit(40, 1'b1);
    check_eq("t3_new_tag_drain", exp_q.size(), 0);

    // Backpressure across three pulses: one pending, one dropped.
    ack_mode = 2;
    time_unit(20, 1'b1);
    check_eq("t4_stalled", out_v, 1);
    time_unit(20, 1'b1);
    check_eq("t4_no_overrun_yet", overrun, 0);
    time_unit(20, 1'b0);
    check_eq("t4_overrun_set", overrun, 1);
    ack_mode = 0;
    repeat (100) @(negedge clk);
    check_eq("t4_overrun_sticky", overrun, 1);
    check_eq("t4_drain", exp_q.size(), 0);

    // Disabled generator keeps its countdown; period 0 disables gen 2.
    gens_en[1] = 1'b0;
    program_gen(1, 2, 1, 'h31);
    program_gen(2, 0, 0, 'h32);
    for (int i = 0; i < 3; i++) begin
      time_unit(40, 1'b1);
      check_eq("t5_disabled_drain", exp_q.size(), 0);
    end
    gens_en[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      time_unit(40, 1'b1);
      check_eq("t5_reenabled_drain", exp_q.size(), 0);
    end

    // Reset while a word is held in EMIT.
    ack_mode = 2;
    time_unit(0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_v) seen = 1'b1;
    end
    check_eq("t6_emit_reached", seen, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_out_v_async", out_v, 0);
    check_eq("t6_overrun_cleared", overrun, 0);
    exp_q.delete();
    for (int g = 0; g < NENTRIES; g++) m_valid[g] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    ack_mode = 0;
    base = n_words;
    for (int i = 0; i < 3; i++) time_unit(40, 1'b1);
    check_eq("t6_silent_after_reset", n_words - base, 0);

    // Randomized programming, enables, sweep length and backpressure.
    ack_mode = 1;
    for (int it = 0; it < 20; it++) begin
      gens_used    = NGENS'($urandom_range(0, 7));
      gens_en[7:0] = 8'($urandom_range(0, 255));
      for (int g = 0; g < 8; g++) begin
        if ($urandom_range(0, 2) == 0) begin
          program_gen(g, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2047)));
        end
      end
      time_unit(150, 1'b1);
      check_eq("rand_drain", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
